ahblite_btn_led: RTL and testbench

- AHB-Lite slave peripheral instantiated inside AHBLITE_SYS. Consumes the raw board `btn` input and produces the `LED[7:0]` output.
- Synchronises and debounces the button, latches press events and raises an interrupt.
- Exposes an LED register, button status, event and control registers to the Cortex-M0 over the AHB-Lite bus.

---
 rtl/ahblite_btn_led_if.sv | 24 ++
 rtl/ahblite_btn_led.sv | 134 +++++++++++++
 tb/tb_ahblite_btn_led.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/ahblite_btn_led_if.sv
// AHB-Lite slave-side bus bundle for the button/LED peripheral.
// The master modport drives the address/data phase; the slave modport answers.
interface ahblite_btn_led_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahblite_btn_led.sv
// AHB-Lite button/LED peripheral: synchronises and debounces btn, latches press
// events into a W1C register, drives LED and a level interrupt.
module ahblite_btn_led #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic             HCLK,
  input  logic             HRESET,
  ahblite_btn_led_if.slave ahb,
  input  logic             btn,
  output logic [7:0]       LED,
  output logic             IRQ,
  output logic [CNT_W-1:0] dbg_cnt,
  output logic             dbg_level
);

  localparam logic [1:0] A_LED    = 2'd0;
  localparam logic [1:0] A_STATUS = 2'd1;
  localparam logic [1:0] A_EVENT  = 2'd2;
  localparam logic [1:0] A_CTRL   = 2'd3;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bus handshake: a transfer is accepted in the address phase when
  // HSEL & HREADY & HTRANS[1]; the slave never stalls (HREADYOUT=1) and never
  // errors (HRESP=0), so every accepted transfer completes in the next cycle.
  logic       valid_q;
  logic       write_q;
  logic [1:0] addr_q;

  logic [7:0]       led_q;
  logic             ctrl_q;
  logic             event_q;
  logic             irq_q;
  logic             s1_q;
  logic             s2_q;
  logic             level_q;
  logic             level_d_q;
  logic [CNT_W-1:0] cnt_q;

  logic        wr_en;
  logic        rise;
  logic [31:0] rdata;
  logic        unused_bits;

  assign wr_en = valid_q & write_q;
  assign rise  = level_q & ~level_d_q;

  // Address-phase latch.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= 2'd0;
    end else if (ahb.HSEL && ahb.HREADY && ahb.HTRANS[1]) begin
      valid_q <= 1'b1;
      write_q <= ahb.HWRITE;
      addr_q  <= ahb.HADDR[3:2];
    end else if (ahb.HREADY) begin
      valid_q <= 1'b0;
    end
  end

  // Register file; a fresh debounced press beats a same-cycle W1C.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      led_q   <= 8'h00;
      ctrl_q  <= 1'b0;
      event_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (wr_en && addr_q == A_LED)
        led_q <= ahb.HWDATA[7:0];
      if (wr_en && addr_q == A_CTRL)
        ctrl_q <= ahb.HWDATA[0];
      if (rise)
        event_q <= 1'b1;
      else if (wr_en && addr_q == A_EVENT && ahb.HWDATA[0])
        event_q <= 1'b0;
      irq_q <= event_q & ctrl_q;
    end
  end

  // Two-flop synchroniser followed by the debounce counter.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      level_q   <= 1'b0;
      level_d_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= btn;
      s2_q      <= s1_q;
      level_d_q <= level_q;
      if (s2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        level_q <= s2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (valid_q && !write_q) begin
      case (addr_q)
        A_LED:    rdata = {24'h0, led_q};
        A_STATUS: rdata = {31'h0, level_q};
        A_EVENT:  rdata = {31'h0, event_q};
        A_CTRL:   rdata = {31'h0, ctrl_q};
        default:  rdata = 32'h0;
      endcase
    end
  end

  assign ahb.HRDATA    = rdata;
  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;

  assign LED       = led_q;
  assign IRQ       = irq_q;
  assign dbg_cnt   = cnt_q;
  assign dbg_level = level_q;

  // Bus fields this word-only, 4-register slave does not decode.
  assign unused_bits = ^{ahb.HSIZE, ahb.HADDR[31:4], ahb.HADDR[1:0], ahb.HWDATA[31:8]};

  a_cnt_bound: assert property (@(posedge HCLK) disable iff (HRESET) cnt_q <= CNT_MAX);

endmodule

// File: tb/tb_ahblite_btn_led.sv
// Directed bench for ahblite_btn_led with DEBOUNCE_CYCLES=8 and a 40 ns clock.
module tb_ahblite_btn_led;
  localparam int DEB = 8;
  localparam int CW  = 4;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          btn;
  logic [7:0]    LED;
  logic          IRQ;
  logic [CW-1:0] dbg_cnt;
  logic          dbg_level;

  ahblite_btn_led_if ahb();

  ahblite_btn_led #(.DEBOUNCE_CYCLES(DEB), .CNT_W(CW)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .ahb       (ahb.slave),
    .btn       (btn),
    .LED       (LED),
    .IRQ       (IRQ),
    .dbg_cnt   (dbg_cnt),
    .dbg_level (dbg_level)
  );

  always #20 HCLK = ~HCLK;

  int          n_checks = 0;
  int          n_errors = 0;
  logic        track = 1'b0;
  int          max_cnt = 0;
  logic [31:0] rd;

  always @(negedge HCLK)
    if (track && int'(dbg_cnt) > max_cnt) max_cnt = int'(dbg_cnt);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    ahb.HSEL   = 1'b0;
    ahb.HTRANS = 2'b00;
    ahb.HWRITE = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge inside the data phase.
  task automatic ahb_write(input logic [3:0] addr, input logic [31:0] data);
    ahb.HSEL   = 1'b1;
    ahb.HTRANS = 2'b10;
    ahb.HWRITE = 1'b1;
    ahb.HADDR  = {28'h0, addr};
    @(negedge HCLK);
    bus_idle();
    ahb.HWDATA = data;
  endtask

  task automatic ahb_read(input logic [3:0] addr, output logic [31:0] data);
    ahb.HSEL   = 1'b1;
    ahb.HTRANS = 2'b10;
    ahb.HWRITE = 1'b0;
    ahb.HADDR  = {28'h0, addr};
    @(negedge HCLK);
    bus_idle();
    data = ahb.HRDATA;
  endtask

  initial begin
    HRESET     = 1'b1;
    btn        = 1'b0;
    ahb.HREADY = 1'b1;
    ahb.HSIZE  = 3'b010;
    ahb.HADDR  = 32'h0;
    ahb.HWDATA = 32'h0;
    bus_idle();
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;

    // Reset state
    check("rst_led", {24'h0, LED}, 32'h0);
    check("rst_irq", {31'h0, IRQ}, 32'h0);
    check("rst_hreadyout", {31'h0, ahb.HREADYOUT}, 32'h1);
    check("rst_hresp", {31'h0, ahb.HRESP}, 32'h0);
    check("rst_hrdata", ahb.HRDATA, 32'h0);
    for (int a = 0; a < 16; a += 4) begin
      ahb_read(4'(a), rd);
      check($sformatf("rst_read_%0h", a), rd, 32'h0);
    end

    // LED register
    ahb_write(4'h0, 32'hA5);
    check("led_before_visible", {24'h0, LED}, 32'h0);
    @(negedge HCLK);
    check("led_a5", {24'h0, LED}, 32'hA5);
    ahb_read(4'h0, rd);
    check("read_led_a5", rd, 32'hA5);

    // Write data phase overlapping a read address phase to the same register
    ahb.HSEL = 1'b1; ahb.HTRANS = 2'b10; ahb.HWRITE = 1'b1; ahb.HADDR = 32'h0;
    @(negedge HCLK);
    ahb.HWDATA = 32'h5A; ahb.HWRITE = 1'b0;
    @(negedge HCLK);
    bus_idle();
    check("b2b_read", ahb.HRDATA, 32'h5A);

    ahb_write(4'h0, 32'h1FF);
    @(negedge HCLK);
    check("led_ff", {24'h0, LED}, 32'hFF);
    ahb_read(4'h0, rd);
    check("read_led_ff", rd, 32'hFF);
    ahb_write(4'h4, 32'hFFFF_FFFF);
    ahb_read(4'h4, rd);
    check("status_ro", rd, 32'h0);

    // Clean press: level changes after DEB+2 edges
    btn = 1'b1;
    repeat (9) @(negedge HCLK);
    check("press_level_early", {31'h0, dbg_level}, 32'h0);
    @(negedge HCLK);
    check("press_level", {31'h0, dbg_level}, 32'h1);
    @(negedge HCLK);
    ahb_read(4'h4, rd);
    check("status_pressed", rd, 32'h1);
    ahb_read(4'h8, rd);
    check("event_pressed", rd, 32'h1);
    check("irq_masked", {31'h0, IRQ}, 32'h0);
    ahb_write(4'hC, 32'h1);
    @(negedge HCLK);
    check("irq_lag", {31'h0, IRQ}, 32'h0);
    @(negedge HCLK);
    check("irq_enabled", {31'h0, IRQ}, 32'h1);
    ahb_read(4'hC, rd);
    check("read_ctrl", rd, 32'h1);

    // Release sets nothing
    btn = 1'b0;
    repeat (12) @(negedge HCLK);
    check("release_level", {31'h0, dbg_level}, 32'h0);
    ahb_read(4'h8, rd);
    check("event_after_release", rd, 32'h1);

    // W1C
    ahb_write(4'h8, 32'h0);
    ahb_read(4'h8, rd);
    check("event_w0", rd, 32'h1);
    check("irq_still", {31'h0, IRQ}, 32'h1);
    ahb_write(4'h8, 32'h1);
    @(negedge HCLK);
    @(negedge HCLK);
    check("irq_cleared", {31'h0, IRQ}, 32'h0);
    ahb_read(4'h8, rd);
    check("event_cleared", rd, 32'h0);

    // Glitchy button: 5 high, 3 low, 5 high
    max_cnt = 0;
    track   = 1'b1;
    btn = 1'b1; repeat (5) @(negedge HCLK);
    btn = 1'b0; repeat (3) @(negedge HCLK);
    btn = 1'b1; repeat (5) @(negedge HCLK);
    btn = 1'b0; repeat (12) @(negedge HCLK);
    track = 1'b0;
    check("glitch_max_cnt", 32'(max_cnt), 32'd5);
    check("glitch_level", {31'h0, dbg_level}, 32'h0);
    ahb_read(4'h4, rd);
    check("glitch_status", rd, 32'h0);
    ahb_read(4'h8, rd);
    check("glitch_event", rd, 32'h0);

    // W1C landing on the same edge as a new debounced rise
    btn = 1'b1;
    repeat (9) @(negedge HCLK);
    ahb_write(4'h8, 32'h1);
    @(negedge HCLK);
    ahb_read(4'h8, rd);
    check("set_beats_w1c", rd, 32'h1);
    check("irq_after_set", {31'h0, IRQ}, 32'h1);
    ahb_write(4'h0, 32'hFF);
    @(negedge HCLK);

    // Reset while btn held
    HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    check("midrst_led", {24'h0, LED}, 32'h0);
    check("midrst_level", {31'h0, dbg_level}, 32'h0);
    check("midrst_irq", {31'h0, IRQ}, 32'h0);
    check("midrst_cnt", {28'h0, dbg_cnt}, 32'h0);
    repeat (9) @(negedge HCLK);
    check("midrst_level_early", {31'h0, dbg_level}, 32'h0);
    @(negedge HCLK);
    check("midrst_level_again", {31'h0, dbg_level}, 32'h1);
    @(negedge HCLK);
    ahb_read(4'h4, rd);
    check("midrst_status", rd, 32'h1);
    ahb_read(4'h8, rd);
    check("midrst_event", rd, 32'h1);
    check("midrst_irq_off", {31'h0, IRQ}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
